spram1_port_arbiter: RTL and testbench

//  Shares one single-port spram1 memory between the instruction-fetch port (read-only)
//  and the data load/store port of the processor.
//  One access is issued per cycle. Data has priority, with a starvation guard that

---
 rtl/spram1_port_arbiter.sv | 126 ++++++++++++
 tb/tb_spram1_port_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/spram1_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spram1_port_arbiter
// Purpose  : Shares one single-port spram1 memory between a read-only
//            instruction-fetch port and a data load/store port. One access
//            is issued per cycle. Data wins by default. After STARVE_LIMIT
//            back-to-back data wins with the instruction port waiting, one
//            instruction grant is forced. Read data comes back one cycle
//            after the grant and is steered to its owner by a registered tag.
// Ports    : clk, resetn (async, active-low)
//            i_req/i_addr -> i_wait, i_rvalid, i_rdata     instruction port
//            d_req/d_wren/d_addr/d_byteen/d_wdata
//                         -> d_wait, d_rvalid, d_rdata     data port
//            mem_address/mem_wren/mem_byteen/mem_data -> spram1, mem_out <- spram1
// Revision : 1.0  initial release
// ============================================================================
module spram1_port_arbiter #(
  parameter int AWIDTH       = 10,
  parameter int DWIDTH       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNTW         = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  // instruction fetch port
  input  logic                  i_req,
  input  logic [AWIDTH-1:0]     i_addr,
  output logic                  i_wait,
  output logic                  i_rvalid,
  output logic [DWIDTH-1:0]     i_rdata,
  // data load/store port
  input  logic                  d_req,
  input  logic                  d_wren,
  input  logic [AWIDTH-1:0]     d_addr,
  input  logic [DWIDTH/8-1:0]   d_byteen,
  input  logic [DWIDTH-1:0]     d_wdata,
  output logic                  d_wait,
  output logic                  d_rvalid,
  output logic [DWIDTH-1:0]     d_rdata,
  // spram1 side
  output logic [AWIDTH-1:0]     mem_address,
  output logic                  mem_wren,
  output logic [DWIDTH/8-1:0]   mem_byteen,
  output logic [DWIDTH-1:0]     mem_data,
  input  logic [DWIDTH-1:0]     mem_out
);

  localparam int              c_bew   = DWIDTH / 8;
  localparam logic [CNTW-1:0] c_limit = CNTW'(STARVE_LIMIT);
  localparam bit              c_guard = (STARVE_LIMIT != 0);

  logic              w_force_i;
  logic              w_d_gnt;
  logic              w_i_gnt;
  logic [CNTW-1:0]   r_streak;
  logic [CNTW-1:0]   w_streak_nxt;
  logic [1:0]        r_rtag;

  // --------------------------------------------------------------------------
  // Grant: data first, unless the instruction port has already watched
  // STARVE_LIMIT consecutive data grants go by.
  // --------------------------------------------------------------------------
  always_comb begin
    w_force_i = c_guard && i_req && (r_streak == c_limit);
    w_d_gnt   = d_req && !w_force_i;
    w_i_gnt   = i_req && !w_d_gnt;
  end

  assign i_wait = i_req && !w_i_gnt;
  assign d_wait = d_req && !w_d_gnt;

  // --------------------------------------------------------------------------
  // Streak counter: counts data wins only while the instruction port waits.
  // It saturates at the limit; with a limit of 0 it is pinned at 0 because
  // r_streak == c_limit holds from reset onward.
  // --------------------------------------------------------------------------
  always_comb begin
    w_streak_nxt = '0;
    if (w_d_gnt && i_req) begin
      if (r_streak == c_limit) begin
        w_streak_nxt = r_streak;
      end else begin
        w_streak_nxt = r_streak + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_streak <= '0;
      r_rtag   <= 2'b00;
    end else begin
      r_streak <= w_streak_nxt;
      // bit 1: instruction read issued, bit 0: data load issued
      r_rtag   <= {w_i_gnt, w_d_gnt && !d_wren};
    end
  end

  // --------------------------------------------------------------------------
  // Memory drive. An idle cycle drives all zeros so nothing downstream
  // depends on stale requester fields.
  // --------------------------------------------------------------------------
  always_comb begin
    mem_address = '0;
    mem_wren    = 1'b0;
    mem_byteen  = '0;
    mem_data    = '0;
    if (w_d_gnt) begin
      mem_address = d_addr;
      mem_wren    = d_wren;
      mem_byteen  = d_byteen;
      mem_data    = d_wdata;
    end else if (w_i_gnt) begin
      mem_address = i_addr;
      mem_byteen  = {c_bew{1'b0}};
    end
  end

  // Read data is shared; only the tagged port sees a valid pulse.
  assign i_rvalid = r_rtag[1];
  assign d_rvalid = r_rtag[0];
  assign i_rdata  = mem_out;
  assign d_rdata  = mem_out;

endmodule
`default_nettype wire

// File: tb/tb_spram1_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spram1_port_arbiter
// Purpose  : Self-checking bench for spram1_port_arbiter. Runs one instance
//            with a starvation limit of 4 and one with pure data priority,
//            both fed from the same stimulus, behind a behavioural spram1.
// Revision : 1.0  initial release
// ============================================================================
module tb_spram1_port_arbiter;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  logic          clk;
  logic          resetn;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          d_req;
  logic          d_wren;
  logic [AW-1:0] d_addr;
  logic [3:0]    d_byteen;
  logic [DW-1:0] d_wdata;

  logic          i_wait, i_rvalid, d_wait, d_rvalid, mem_wren;
  logic [DW-1:0] i_rdata, d_rdata, mem_data, mem_out;
  logic [AW-1:0] mem_address;
  logic [3:0]    mem_byteen;

  logic          i_wait0, i_rvalid0, d_wait0, d_rvalid0, mem_wren0;
  logic [DW-1:0] i_rdata0, d_rdata0, mem_data0;
  logic [AW-1:0] mem_address0;
  logic [3:0]    mem_byteen0;

  spram1_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .STARVE_LIMIT(LIMIT), .CNTW(8)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_wait(i_wait), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_wren(d_wren), .d_addr(d_addr), .d_byteen(d_byteen), .d_wdata(d_wdata),
    .d_wait(d_wait), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_address(mem_address), .mem_wren(mem_wren), .mem_byteen(mem_byteen),
    .mem_data(mem_data), .mem_out(mem_out)
  );

  spram1_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .STARVE_LIMIT(0), .CNTW(8)) dut0 (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_wait(i_wait0), .i_rvalid(i_rvalid0), .i_rdata(i_rdata0),
    .d_req(d_req), .d_wren(d_wren), .d_addr(d_addr), .d_byteen(d_byteen), .d_wdata(d_wdata),
    .d_wait(d_wait0), .d_rvalid(d_rvalid0), .d_rdata(d_rdata0),
    .mem_address(mem_address0), .mem_wren(mem_wren0), .mem_byteen(mem_byteen0),
    .mem_data(mem_data0), .mem_out(mem_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // byteen MSB selects the lowest byte lane
  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int k = 0; k < 4; k++)
      if (be[3-k]) r[8*k +: 8] = new_w[8*k +: 8];
    return r;
  endfunction

  // Behavioural spram1 driven by the limit-4 instance: registered read, old data on RAW.
  logic [31:0] env_mem [0:1023];
  always @(posedge clk) begin
    mem_out <= env_mem[mem_address];
    if (mem_wren) env_mem[mem_address] <= merge(env_mem[mem_address], mem_data, mem_byteen);
  end

  // Reference model state
  logic [31:0] ref_mem [0:1023];
  int          m_cnt;
  bit          exp_irv, exp_drv, last_ig, last_dg;
  logic [31:0] exp_rdata;
  int          g0_dgnt;
  int          checks;
  int          failures;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock cycle: check outputs at negedge, advance the model at posedge.
  task automatic step();
    bit fi, dg, ig;
    @(negedge clk);
    fi = (LIMIT != 0) && i_req && (m_cnt == LIMIT);
    dg = d_req && !fi;
    ig = i_req && !dg;
    chk("i_wait", i_wait, i_req && !ig);
    chk("d_wait", d_wait, d_req && !dg);
    chk("mem_wren", mem_wren, dg && d_wren);
    chk("mem_address", mem_address, dg ? d_addr : (ig ? i_addr : '0));
    chk("mem_byteen", mem_byteen, dg ? d_byteen : 4'h0);
    if (!ig) chk("mem_data", mem_data, dg ? d_wdata : 32'h0);
    chk("i_rvalid", i_rvalid, exp_irv);
    chk("d_rvalid", d_rvalid, exp_drv);
    if (exp_irv) chk("i_rdata", i_rdata, exp_rdata);
    if (exp_drv) chk("d_rdata", d_rdata, exp_rdata);
    chk("prio_i_wait", i_wait0, i_req && d_req);
    chk("prio_d_wait", d_wait0, 1'b0);
    if (d_req && !d_wait0) g0_dgnt++;
    @(posedge clk);
    exp_irv = ig;
    exp_drv = dg && !d_wren;
    if (ig) exp_rdata = ref_mem[i_addr];
    else if (dg) exp_rdata = ref_mem[d_addr];
    if (dg && d_wren) ref_mem[d_addr] = merge(ref_mem[d_addr], d_wdata, d_byteen);
    if (dg && i_req) m_cnt = (m_cnt + 1 > LIMIT) ? LIMIT : m_cnt + 1;
    else m_cnt = 0;
    last_ig = ig;
    last_dg = dg;
    #1;
  endtask

  initial begin
    checks = 0; failures = 0; m_cnt = 0; g0_dgnt = 0;
    exp_irv = 0; exp_drv = 0; last_ig = 0; last_dg = 0; exp_rdata = '0;
    resetn = 1'b0; i_req = 0; i_addr = '0; d_req = 0; d_wren = 0;
    d_addr = '0; d_byteen = '0; d_wdata = '0;
    for (int a = 0; a < 1024; a++) begin
      env_mem[a] = 32'h9E37_79B9 * a + 32'h1357;
      ref_mem[a] = env_mem[a];
    end
    env_mem[10'h010] = 32'hDEADBEEF; ref_mem[10'h010] = 32'hDEADBEEF;
    env_mem[10'h011] = 32'h11223344; ref_mem[10'h011] = 32'h11223344;
    env_mem[10'h020] = 32'h0BADF00D; ref_mem[10'h020] = 32'h0BADF00D;

    // Reset state
    step(); step();
    resetn = 1'b1;
    step();

    // Single load
    d_req = 1; d_wren = 0; d_addr = 10'h010;
    step();
    d_req = 0;
    chk("load_rvalid", d_rvalid, 1'b1);
    chk("load_data", d_rdata, 32'hDEADBEEF);
    chk("load_no_irvalid", i_rvalid, 1'b0);
    step();

    // Byte store then load
    d_req = 1; d_wren = 1; d_addr = 10'h011; d_byteen = 4'b0010; d_wdata = 32'h00AA0000;
    step();
    d_req = 0; d_wren = 0;
    chk("store_no_rvalid", d_rvalid, 1'b0);
    step();
    d_req = 1; d_addr = 10'h011; d_byteen = 4'h0;
    step();
    d_req = 0;
    chk("bytestore_data", d_rdata, 32'h11AA3344);
    step();

    // Contention with starvation guard, then reset right after an I grant
    i_req = 1; i_addr = 10'h030; d_req = 1; d_wren = 0; d_addr = 10'h031;
    for (int k = 0; k < 12; k++) step();
    for (int k = 0; k < 6 && !last_ig; k++) step();
    chk("contention_i_grant_seen", last_ig, 1'b1);
    chk("pre_reset_irvalid", i_rvalid, 1'b1);
    resetn = 1'b0; i_req = 0; d_req = 0;
    #1;
    chk("reset_drops_irvalid", i_rvalid, 1'b0);
    exp_irv = 0; exp_drv = 0; m_cnt = 0;
    step(); step();
    resetn = 1'b1;
    i_req = 1; d_req = 1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("post_reset_seq", last_ig, (k % 5) == 4);
    end
    i_req = 0; d_req = 0;
    step();

    // Pure priority on the limit-0 instance
    g0_dgnt = 0;
    i_req = 1; d_req = 1;
    for (int k = 0; k < 20; k++) step();
    chk("prio_data_grants", g0_dgnt, 20);
    i_req = 0; d_req = 0;
    step(); step();

    // Interleave: instruction read, store, then load to the same word
    i_req = 1; i_addr = 10'h020;
    step();
    i_req = 0;
    d_req = 1; d_wren = 1; d_addr = 10'h020; d_byteen = 4'hF; d_wdata = 32'hCAFEF00D;
    #1;
    chk("interleave_old", i_rdata, 32'h0BADF00D);
    step();
    d_wren = 0;
    step();
    d_req = 0;
    chk("interleave_new", d_rdata, 32'hCAFEF00D);
    step();

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      i_req  = (i_req && !last_ig) ? 1'b1 : 1'($urandom_range(0, 1));
      d_req  = (d_req && !last_dg) ? 1'b1 : 1'($urandom_range(0, 1));
      i_addr = 10'($urandom_range(0, 15));
      d_addr = 10'($urandom_range(0, 15));
      d_wren = 1'($urandom_range(0, 1));
      d_byteen = 4'($urandom_range(0, 15));
      d_wdata  = $urandom;
      step();
    end
    i_req = 0; d_req = 0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
